// File: rtl/rvga_types.sv
// Shared types for the rvga decode path: machine word, decoded control word,
// queue entry layout, decode-stage state and major opcode values.
package rvga_types;

  typedef logic [31:0] rvga_word;

  // Decoded control word produced by decode_dp and registered by the stage.
  typedef struct packed {
    rvga_word   pc;
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       alu_v;
    logic       ld_v;
    logic       st_v;
    logic       br_v;
    logic       jmp_v;
    logic       rd_we;
  } rvga_decode_cword;

  // One buffered fetch slot.
  typedef struct packed {
    rvga_word pc;
    rvga_word ir;
  } rvga_decode_q_entry;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } rvga_decode_state_e;

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/decode_dp.sv
// Combinational decode datapath: splits an instruction word into its raw
// register/function fields and classifies it by major opcode.
module decode_dp
  import rvga_types::*;
(
  input  rvga_word         pc_i,
  input  rvga_word         ir_i,
  output rvga_decode_cword cword_o
);

  // Field extraction and opcode classification.
  always_comb begin
    // NOTE: assign a default to every field first so no path leaves a field
    // unassigned; otherwise synthesis infers a latch.
    cword_o        = '0;
    cword_o.pc     = pc_i;
    cword_o.funct7 = ir_i[31:25];
    cword_o.rs2    = ir_i[24:20];
    cword_o.rs1    = ir_i[19:15];
    cword_o.funct3 = ir_i[14:12];
    cword_o.rd     = ir_i[11:7];
    case (ir_i[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LUI: cword_o.alu_v = 1'b1;
      OPC_LOAD:                    cword_o.ld_v  = 1'b1;
      OPC_STORE:                   cword_o.st_v  = 1'b1;
      OPC_BRANCH:                  cword_o.br_v  = 1'b1;
      OPC_JAL, OPC_JALR:           cword_o.jmp_v = 1'b1;
      default: ;
    endcase
    cword_o.rd_we = cword_o.alu_v | cword_o.ld_v | cword_o.jmp_v;
  end

endmodule

// File: rtl/decode_fifo.sv
// Power-of-two circular queue with occupancy count, synchronous clear and
// asynchronous reset. Push on full and pop on empty are ignored.
module decode_fifo #(
  parameter int depth_p     = 4,
  parameter int width_p     = 64,
  parameter int cnt_width_p = $clog2(depth_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [width_p-1:0]     data_i,
  output logic [width_p-1:0]     data_o,
  output logic [cnt_width_p-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int ptr_w = $clog2(depth_p);
  localparam logic [cnt_width_p-1:0] full_cnt = cnt_width_p'(depth_p);

  logic [width_p-1:0] mem [depth_p];
  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full_o  = (count_o == full_cnt);
  assign empty_o = (count_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  // Storage write; contents are qualified by count, never by reset.
  // NOTE: the storage array has no reset branch -- stale data is harmless
  // because count gates every read, and a reset here would turn RAM into flops.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem[wr_ptr] <= data_i;
  end

  // Pointer and occupancy update; pointers wrap naturally at depth_p.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (clr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_o <= count_o + cnt_width_p'(1);
        2'b01:   count_o <= count_o - cnt_width_p'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Queued decode stage between fetch and execute: buffers (pc, ir) pairs,
// decodes the head into a registered control word and optionally holds issue
// after a branch until it resolves (br_stall_p).
// Build option: define DECODE_QUEUE_STAGE_BYPASS_EN to let an instruction
// skip an empty queue and load straight into the output register.
module decode_queue_stage
  import rvga_types::*;
#(
  parameter int depth_p     = 4,
  parameter int br_stall_p  = 1,
  parameter int cnt_width_p = $clog2(depth_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_v_i,
  input  logic                   fetch_v_i,
  output logic                   fetch_rdy_o,
  input  rvga_word               pc_i,
  input  rvga_word               ir_i,
  output logic                   cword_v_o,
  output rvga_decode_cword       cword_o,
  input  logic                   exe_rdy_i,
  output logic                   br_v_o,
  input  logic                   br_resolve_i,
  output logic [cnt_width_p-1:0] count_o
);

  localparam int entry_w = $bits(rvga_decode_q_entry);

  rvga_decode_q_entry  wr_entry;
  rvga_decode_q_entry  head;
  logic [entry_w-1:0]  head_bits;
  logic                fifo_full;
  logic                fifo_empty;
  logic                out_free;
  logic                run;
  logic                load_q;
  logic                bypass;
  logic                push;
  logic                pop;
  logic                load;
  rvga_word            dp_pc;
  rvga_word            dp_ir;
  rvga_decode_cword    dp_cword;
  rvga_decode_state_e  state;

  assign wr_entry    = '{pc: pc_i, ir: ir_i};
  assign head        = rvga_decode_q_entry'(head_bits);
  assign fetch_rdy_o = !fifo_full;
  assign out_free    = !cword_v_o || exe_rdy_i;
  assign run         = (state == RUN);
  assign load_q      = !fifo_empty && out_free && run;

`ifdef DECODE_QUEUE_STAGE_BYPASS_EN
  // Empty queue implies not full, so the bypassed fetch is always accepted.
  assign bypass = fifo_empty && fetch_v_i && out_free && run && !flush_v_i;
`else
  assign bypass = 1'b0;
`endif

  assign push   = fetch_v_i && fetch_rdy_o && !flush_v_i && !bypass;
  assign pop    = load_q && !flush_v_i;
  assign load   = load_q || bypass;
  assign dp_pc  = bypass ? pc_i : head.pc;
  assign dp_ir  = bypass ? ir_i : head.ir;
  assign br_v_o = cword_v_o && cword_o.br_v;

  decode_fifo #(
    .depth_p    (depth_p),
    .width_p    (entry_w),
    .cnt_width_p(cnt_width_p)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_v_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (wr_entry),
    .data_o (head_bits),
    .count_o(count_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  decode_dp u_dp (
    .pc_i   (dp_pc),
    .ir_i   (dp_ir),
    .cword_o(dp_cword)
  );

  // Output register and RUN/HOLD issue state; flush overrides everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cword_v_o <= 1'b0;
      cword_o   <= '0;
      state     <= RUN;
    end else if (flush_v_i) begin
      cword_v_o <= 1'b0;
      cword_o   <= '0;
      state     <= RUN;
    end else begin
      if (load) begin
        cword_o   <= dp_cword;
        cword_v_o <= 1'b1;
      end else if (exe_rdy_i) begin
        cword_v_o <= 1'b0;
      end
      // A newly loaded branch wins over a same-cycle resolve.
      if ((br_stall_p != 0) && load && dp_cword.br_v) state <= HOLD;
      else if (state == HOLD && br_resolve_i)          state <= RUN;
    end
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Self-checking bench for decode_queue_stage: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based reference model of the stage.
module tb_decode_queue_stage;
  import rvga_types::*;

  localparam int DEPTH    = 4;
  localparam int BR_STALL = 1;
  localparam int CW       = $clog2(DEPTH + 1);
`ifdef DECODE_QUEUE_STAGE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  localparam rvga_word I_ALU = 32'h002081B3;
  localparam rvga_word I_BR  = 32'h00208463;

  logic             clk;
  logic             rst;
  logic             flush_v;
  logic             fetch_v;
  logic             fetch_rdy;
  rvga_word         pc;
  rvga_word         ir;
  logic             cword_v;
  rvga_decode_cword cword;
  logic             exe_rdy;
  logic             br_v;
  logic             br_resolve;
  logic [CW-1:0]    count;

  decode_queue_stage #(
    .depth_p    (DEPTH),
    .br_stall_p (BR_STALL),
    .cnt_width_p(CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_v_i   (flush_v),
    .fetch_v_i   (fetch_v),
    .fetch_rdy_o (fetch_rdy),
    .pc_i        (pc),
    .ir_i        (ir),
    .cword_v_o   (cword_v),
    .cword_o     (cword),
    .exe_rdy_i   (exe_rdy),
    .br_v_o      (br_v),
    .br_resolve_i(br_resolve),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, an output slot and a hold flag.
  rvga_decode_q_entry mq[$];
  logic               mv;
  rvga_decode_cword   mc;
  logic               mhold;
  rvga_word           consumed[$];

  function automatic rvga_decode_cword model_decode(input rvga_word p, input rvga_word w);
    rvga_decode_cword c;
    c        = '0;
    c.pc     = p;
    c.funct7 = w[31:25];
    c.rs2    = w[24:20];
    c.rs1    = w[19:15];
    c.funct3 = w[14:12];
    c.rd     = w[11:7];
    c.alu_v  = (w[6:0] == 7'h33) || (w[6:0] == 7'h13) || (w[6:0] == 7'h37);
    c.ld_v   = (w[6:0] == 7'h03);
    c.st_v   = (w[6:0] == 7'h23);
    c.br_v   = (w[6:0] == 7'h63);
    c.jmp_v  = (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
    c.rd_we  = c.alu_v || c.ld_v || c.jmp_v;
    return c;
  endfunction

  task automatic model_reset();
    mq.delete();
    mv    = 1'b0;
    mc    = '0;
    mhold = 1'b0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit full, accept, free, byp, ld;
    rvga_decode_cword   nc;
    rvga_decode_q_entry e;
    full   = (mq.size() == DEPTH);
    accept = fetch_v && !full;
    free   = !mv || exe_rdy;
    byp    = 1'b0;
    ld     = 1'b0;
    nc     = '0;
    if (flush_v) begin
      model_reset();
    end else begin
`ifdef DECODE_QUEUE_STAGE_BYPASS_EN
      byp = (mq.size() == 0) && fetch_v && free && !mhold;
`endif
      if (mq.size() > 0 && free && !mhold) begin
        nc = model_decode(mq[0].pc, mq[0].ir);
        void'(mq.pop_front());
        ld = 1'b1;
      end else if (byp) begin
        nc = model_decode(pc, ir);
        ld = 1'b1;
      end
      if (ld) begin
        mc = nc;
        mv = 1'b1;
      end else if (exe_rdy) begin
        mv = 1'b0;
      end
      if (BR_STALL != 0 && ld && nc.br_v) mhold = 1'b1;
      else if (mhold && br_resolve)       mhold = 1'b0;
      if (accept && !byp) begin
        e.pc = pc;
        e.ir = ir;
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare();
    check("count", 64'(count), 64'(mq.size()));
    check("fetch_rdy", 64'(fetch_rdy), 64'(mq.size() < DEPTH));
    check("cword_v", 64'(cword_v), 64'(mv));
    check("cword", 64'(cword), 64'(mc));
    check("br_v", 64'(br_v), 64'(mv && mc.br_v));
  endtask

  // One clock: record consumption, step the model, clock, compare.
  task automatic cycle();
    if (cword_v && exe_rdy) consumed.push_back(cword.pc);
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic offer(input bit v, input rvga_word p, input rvga_word w);
    fetch_v = v;
    pc      = p;
    ir      = w;
  endtask

  function automatic rvga_word rand_ir();
    rvga_word r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0:       r[6:0] = 7'h33;
      1:       r[6:0] = 7'h13;
      2:       r[6:0] = 7'h03;
      3:       r[6:0] = 7'h23;
      4:       r[6:0] = 7'h63;
      default: r[6:0] = 7'h6F;
    endcase
    return r;
  endfunction

  initial begin
    rvga_word rpc;
    int       exe_pct;
    int       fetch_pct;

    rst = 1'b1; flush_v = 1'b0; br_resolve = 1'b0; exe_rdy = 1'b0;
    offer(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare();
    check("reset_rdy_lit", 64'(fetch_rdy), 64'd1);
    check("reset_cnt_lit", 64'(count), 64'd0);

    // Asynchronous reset mid-stream: 3 queued, register valid.
    exe_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h40 + 32'(4 * i), I_ALU);
      cycle();
    end
    check("pre_rst_cnt", 64'(count), 64'd3);
    check("pre_rst_v", 64'(cword_v), 64'd1);
    offer(1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_cnt", 64'(count), 64'd0);
    check("rst_v", 64'(cword_v), 64'd0);
    check("rst_cword", 64'(cword), 64'd0);
    check("rst_rdy", 64'(fetch_rdy), 64'd1);
    check("rst_brv", 64'(br_v), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare();

    // Streaming with execute always ready.
    exe_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      offer(i < 4, 32'(4 * i), I_ALU);
      cycle();
      check("stream_cnt_le1", 64'(count <= 1), 64'd1);
      if (i + 1 >= LAT && i + 1 - LAT <= 3) begin
        check("stream_v", 64'(cword_v), 64'd1);
        check("stream_pc", 64'(cword.pc), 64'(4 * (i + 1 - LAT)));
      end else begin
        check("stream_idle", 64'(cword_v), 64'd0);
      end
    end

    // Backpressure: six offered, five accepted, drained in order.
    exe_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(1'b1, 32'h80 + 32'(4 * i), I_ALU);
      cycle();
      if (i == 4) check("bp_rdy_low", 64'(fetch_rdy), 64'd0);
    end
    check("bp_cnt", 64'(count), 64'd4);
    check("bp_rdy", 64'(fetch_rdy), 64'd0);
    check("bp_head_pc", 64'(cword.pc), 64'h80);
    offer(1'b0, '0, '0);
    exe_rdy = 1'b1;
    consumed.delete();
    repeat (8) cycle();
    check("bp_drained", 64'(consumed.size()), 64'd5);
    for (int k = 0; k < 5 && k < consumed.size(); k++)
      check("bp_order", 64'(consumed[k]), 64'(32'h80 + 32'(4 * k)));

    // Branch hold then resolve.
    for (int k = 1; k <= 3; k++) begin
      offer(1'b1, 32'h100 + 32'(4 * (k - 1)), (k == 1) ? I_BR : I_ALU);
      cycle();
      if (k == LAT) begin
        check("hold_brv", 64'(br_v), 64'd1);
        check("hold_br_pc", 64'(cword.pc), 64'h100);
      end
    end
    check("hold_v", 64'(cword_v), 64'd0);
    check("hold_cnt", 64'(count), 64'd2);
    offer(1'b0, '0, '0);
    cycle();
    check("hold_still_cnt", 64'(count), 64'd2);
    br_resolve = 1'b1;
    cycle();
    br_resolve = 1'b0;
    check("resolve_v", 64'(cword_v), 64'd0);
    cycle();
    check("after_res_v", 64'(cword_v), 64'd1);
    check("after_res_pc", 64'(cword.pc), 64'h104);
    check("after_res_cnt", 64'(count), 64'd1);
    repeat (3) cycle();

    // Resolve colliding with a new branch load.
    offer(1'b1, 32'h200, I_BR);
    cycle();
    offer(1'b1, 32'h204, I_BR);
    cycle();
    br_resolve = 1'b1;
    offer(1'b1, 32'h208, I_ALU);
    cycle();
    offer(1'b0, '0, '0);
    cycle();
    check("coll_pc", 64'(cword.pc), 64'h204);
    check("coll_brv", 64'(br_v), 64'd1);
    check("coll_cnt", 64'(count), 64'd1);
    br_resolve = 1'b0;
    repeat (2) cycle();
    check("coll_hold_v", 64'(cword_v), 64'd0);
    check("coll_hold_cnt", 64'(count), 64'd1);
    br_resolve = 1'b1;
    cycle();
    br_resolve = 1'b0;
    repeat (3) cycle();

    // Flush with queue at 3, register valid, HOLD and a concurrent push.
    exe_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h300 + 32'(4 * i), (i == 0) ? I_BR : I_ALU);
      cycle();
    end
    check("pre_fl_cnt", 64'(count), 64'd3);
    check("pre_fl_brv", 64'(br_v), 64'd1);
    flush_v = 1'b1;
    offer(1'b1, 32'h310, I_ALU);
    cycle();
    flush_v = 1'b0;
    check("fl_cnt", 64'(count), 64'd0);
    check("fl_v", 64'(cword_v), 64'd0);
    check("fl_cword", 64'(cword), 64'd0);
    check("fl_rdy", 64'(fetch_rdy), 64'd1);
    exe_rdy = 1'b1;
    offer(1'b1, 32'h314, I_ALU);
    for (int k = 0; k < LAT; k++) begin
      cycle();
      offer(1'b0, '0, '0);
    end
    check("fl_run_v", 64'(cword_v), 64'd1);
    check("fl_run_pc", 64'(cword.pc), 64'h314);
    cycle();

    // Randomized traffic in phases of varying pressure.
    rpc = 32'h1000;
    exe_pct = 50;
    fetch_pct = 70;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       exe_pct = 10;
          1:       exe_pct = 50;
          2:       exe_pct = 90;
          default: exe_pct = 100;
        endcase
        fetch_pct = $urandom_range(30, 100);
      end
      offer($urandom_range(0, 99) < fetch_pct, rpc, rand_ir());
      exe_rdy    = $urandom_range(0, 99) < exe_pct;
      br_resolve = $urandom_range(0, 99) < 8;
      flush_v    = $urandom_range(0, 99) < 2;
      if (fetch_v && fetch_rdy) rpc = rpc + 32'd4;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Parametrised successor of the single-register decode stage.
- Sits between fetch and execute and buffers fetched (pc, ir) pairs in a depth_p-entry queue.
- Decodes the queue head through the existing decode_dp datapath into a registered rvga_decode_cword.
- Adds valid/ready handshakes on both sides and an optional issue hold after branches until the branch resolves.

Parameters:
- depth_p, 4: queue entries. Power of two, minimum 2.
- br_stall_p, 1: 1 = block further issue after a branch is loaded until resolve or flush. 0 = no hold.
- cnt_width_p, $clog2(depth_p+1): width of the occupancy counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_v_i  in  1  discard everything held in the stage.
- fetch_v_i  in  1  fetch offers pc_i/ir_i.
- fetch_rdy_o  out  1  stage can accept.
- pc_i  in  $bits(rvga_word)  instruction pc.
- ir_i  in  $bits(rvga_word)  instruction word.
- cword_v_o  out  1  cword_o valid.
- cword_o  out  $bits(rvga_decode_cword)  registered decoded control word.
- exe_rdy_i  in  1  execute consumes cword_o this cycle.
- br_v_o  out  1  cword_v_o && cword_o.br_v.
- br_resolve_i  in  1  outstanding branch resolved; releases hold.
- count_o  out  cnt_width_p  queue occupancy (excludes the output register).

Behaviour:
- Reset, applied asynchronously while rst_i is high:
  - Queue pointers and count_o = 0.
  - cword_v_o = 0, cword_o = '0, br_v_o = 0.
  - State = RUN.
  - fetch_rdy_o = 1 (queue empty).
  - Reset mid-operation drops all queued and registered instructions.
- Push when fetch_v_i && fetch_rdy_o.
- fetch_rdy_o = !full (count_o == depth_p means full). It does not depend on a same-cycle pop, so a full queue never accepts even while popping.
- Load condition: load = !empty && (!cword_v_o || exe_rdy_i) && (state == RUN). On load:
  - Head entry popped.
  - decode_dp(head.pc, head.ir) registered into cword_o.
  - cword_v_o = 1.
- If the register is not loaded and exe_rdy_i && cword_v_o: cword_v_o <= 0. cword_o keeps its value.
- Minimum latency without the optional feature: a push accepted in cycle t is visible on cword_o in cycle t+2.
- Throughput: 1 instruction/cycle when exe_rdy_i is held high.
- Pointers wrap modulo depth_p.
- count_o changes as follows: push-only +1, pop-only -1, push+pop unchanged.
- State machine RUN/HOLD, only when br_stall_p=1:
  - RUN -> HOLD when a loaded cword has br_v=1.
  - HOLD -> RUN on br_resolve_i.
  - In HOLD there are no loads, but the output register may still be consumed and pushes continue until full.
  - br_resolve_i in RUN is ignored.
  - A branch load and br_resolve_i in the same cycle give HOLD, because the new branch wins.
- When br_stall_p=0, state stays RUN permanently.
- flush_v_i has highest priority and takes effect at the next edge:
  - Queue emptied, count_o = 0.
  - cword_v_o = 0, cword_o = '0.
  - State = RUN.
  - A same-cycle push, load or resolve is discarded.
  - fetch_rdy_o is not gated by flush.

Optional Feature:
- Macro: DECODE_QUEUE_STAGE_BYPASS_EN.
- When defined: if the queue is empty, fetch_v_i is high, the load condition ignoring !empty holds, and there is no flush, then pc_i/ir_i are decoded and loaded straight into cword_o. The queue is untouched. Latency is 1 (push in t, visible in t+1).
- When undefined: every instruction passes through the queue, with a minimum latency of 2.
- Ordering is preserved in both builds, because bypass is only possible when the queue is empty.

Decomposition:
- In rvga_types:
  - typedef rvga_decode_q_entry, a packed struct {rvga_word pc; rvga_word ir;}.
  - enum rvga_decode_state_e {RUN, HOLD}.
- Sub-module decode_fifo, parametrised by depth_p and width_p = $bits(rvga_decode_q_entry). It provides:
  - Storage and read/write pointers.
  - count_o, full_o, empty_o.
  - Synchronous clear on flush.
  - Asynchronous reset.
- Top level instantiates decode_fifo and decode_dp, and holds the output register and the RUN/HOLD state.

Test Plan:
- Reset: assert rst_i mid-stream with 3 entries queued and cword_v_o=1 -> same cycle count_o=0, cword_v_o=0, cword_o='0, fetch_rdy_o=1.
- Streaming: push pc 0x0,0x4,0x8,0xC on consecutive cycles with exe_rdy_i=1 -> cword_o emerges in order. First output at t+2 (t+1 with BYPASS_EN), then one per cycle. count_o never exceeds 1.
- Backpressure/full with depth_p=4: exe_rdy_i=0 and push 6 instructions:
  - The output register holds instruction 1 and the queue takes 4, so count_o=4 and fetch_rdy_o=0.
  - The 6th instruction is not accepted.
  - After exe_rdy_i=1, all 5 accepted instructions drain in order.
- Branch hold with br_stall_p=1:
  - Issue a branch followed by 2 ALU ops -> br_v_o=1. After consumption cword_v_o stays 0 and count_o=2.
  - br_resolve_i pulse -> the next op loads the following cycle.
- Resolve/branch collision: br_resolve_i asserted in the same cycle a new branch loads -> state remains HOLD and no further loads.
- Flush: flush_v_i with count_o=3, cword_v_o=1, HOLD and a concurrent push -> next cycle count_o=0, cword_v_o=0, RUN, and the pushed instruction never appears.
